// File: rtl/burst_data_pipe.sv
// burst_data_pipe: request FIFO, ACT -> CAS sequencer and a one-deep write/read burst engine.
// Define BURST_CHOP_EN to store cfg_bl4 per entry (BL4 bursts, CAS address bit 12 cleared for chop).
module burst_data_pipe #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned TA_WIDTH   = 29,
    parameter int unsigned ADDR_LSB   = 3,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned BL_MAX     = 8,
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned DLY_W      = 6
) (
    input  logic                         clock_t,
    input  logic                         reset_n,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic                         req_rw,
    input  logic [ADDR_WIDTH-1:0]        req_addr,
    input  logic [BL_MAX*DATA_WIDTH-1:0] req_wdata,
    input  logic [DLY_W-1:0]             cfg_trcd,
    input  logic [DLY_W-1:0]             cfg_tccd,
    input  logic [DLY_W-1:0]             cfg_wr_delay,
    input  logic [DLY_W-1:0]             cfg_rd_delay,
    input  logic                         cfg_bl4,
    output logic                         cmd_valid,
    output logic [1:0]                   cmd_code,
    output logic [TA_WIDTH-1:0]          cmd_addr,
    output logic                         wdata_valid,
    output logic [DATA_WIDTH-1:0]        wdata,
    output logic                         rd_window,
    output logic                         busy
);
    localparam int unsigned PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W   = $clog2(DEPTH + 1);
    localparam int unsigned BEAT_W  = $clog2(BL_MAX + 1);
    localparam int unsigned BURST_W = BL_MAX * DATA_WIDTH;

    typedef struct packed {
        logic                rw;
`ifdef BURST_CHOP_EN
        logic                bl4;
`endif
        logic [TA_WIDTH-1:0] addr;
        logic [BURST_W-1:0]  data;
    } entry_t;

    typedef enum logic [2:0] {S_IDLE, S_ACT, S_WAIT_RCD, S_CAS, S_WAIT_CCD} state_t;

    // A programmed spacing of 0 behaves as 1.
    function automatic logic [DLY_W-1:0] eff(input logic [DLY_W-1:0] v);
        return (v == '0) ? DLY_W'(1) : v;
    endfunction

    entry_t              mem [DEPTH];
    entry_t              head, push_entry;
    logic [PTR_W-1:0]    wr_ptr, rd_ptr;
    logic [CNT_W-1:0]    count, count_nxt;
    logic                push, pop;
    state_t              state, state_nxt;
    logic [DLY_W-1:0]    cnt;
    logic [TA_WIDTH-1:0] cas_addr;
    logic [BEAT_W-1:0]   head_bl;
    logic                eng_wait, eng_run, eng_idle, eng_busy_nxt, eng_rw;
    logic [DLY_W-1:0]    eng_dly;
    logic [BEAT_W-1:0]   eng_beat, eng_bl;
    logic [BURST_W-1:0]  eng_data;
    logic                unused_in;

    assign unused_in = ^{cfg_bl4, req_addr};
    assign head      = mem[rd_ptr];
    assign push      = req_valid && req_ready;
    assign pop       = (state == S_CAS);
    assign eng_idle  = !eng_wait && !eng_run;

    // Physical-to-memory address mapping happens once, at push.
    always_comb begin
        push_entry      = '0;
        push_entry.rw   = req_rw;
        push_entry.addr = req_addr[ADDR_LSB +: TA_WIDTH];
        push_entry.data = req_wdata;
`ifdef BURST_CHOP_EN
        push_entry.bl4  = cfg_bl4;
`endif
    end

    always_comb begin
        count_nxt = count;
        if (push && !pop)
            count_nxt = count + CNT_W'(1);
        else if (pop && !push)
            count_nxt = count - CNT_W'(1);
    end

    always_ff @(posedge clock_t or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            req_ready <= 1'b1;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count     <= count_nxt;
            req_ready <= (count_nxt != CNT_W'(DEPTH));
        end
    end

    // Storage needs no reset; validity is carried by the pointers and count.
    always_ff @(posedge clock_t) begin
        if (push) mem[wr_ptr] <= push_entry;
    end

    // Command sequencer next state.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:     if (count != '0 && eng_idle) state_nxt = S_ACT;
            S_ACT:      state_nxt = (eff(cfg_trcd) == DLY_W'(1)) ? S_CAS : S_WAIT_RCD;
            S_WAIT_RCD: if (cnt <= DLY_W'(1)) state_nxt = S_CAS;
            S_CAS:      state_nxt = (eff(cfg_tccd) == DLY_W'(1)) ? S_IDLE : S_WAIT_CCD;
            S_WAIT_CCD: if (cnt <= DLY_W'(1)) state_nxt = S_IDLE;
            default:    state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock_t or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                S_ACT:                  cnt <= eff(cfg_trcd) - DLY_W'(1);
                S_CAS:                  cnt <= eff(cfg_tccd) - DLY_W'(1);
                S_WAIT_RCD, S_WAIT_CCD: cnt <= cnt - DLY_W'(1);
                default:                cnt <= cnt;
            endcase
        end
    end

    always_comb begin
        cas_addr = head.addr;
        head_bl  = BEAT_W'(BL_MAX);
`ifdef BURST_CHOP_EN
        cas_addr[12] = !head.bl4;
        if (head.bl4) head_bl = BEAT_W'(4);
`endif
    end

    // Command strobe is a one-cycle registered image of the ACT/CAS states.
    always_ff @(posedge clock_t or negedge reset_n) begin
        if (!reset_n) begin
            cmd_valid <= 1'b0;
            cmd_code  <= 2'd0;
            cmd_addr  <= '0;
        end else begin
            cmd_valid <= 1'b0;
            cmd_code  <= 2'd0;
            cmd_addr  <= '0;
            if (state == S_ACT) begin
                cmd_valid <= 1'b1;
                cmd_code  <= 2'd1;
                cmd_addr  <= head.addr;
            end else if (state == S_CAS) begin
                cmd_valid <= 1'b1;
                cmd_code  <= head.rw ? 2'd3 : 2'd2;
                cmd_addr  <= cas_addr;
            end
        end
    end

    // Burst engine: delay countdown, then eng_bl gap-free beats; beat data shifts out LSB first.
    always_ff @(posedge clock_t or negedge reset_n) begin
        if (!reset_n) begin
            eng_wait    <= 1'b0;
            eng_run     <= 1'b0;
            eng_rw      <= 1'b0;
            eng_dly     <= '0;
            eng_beat    <= '0;
            eng_bl      <= '0;
            eng_data    <= '0;
            wdata_valid <= 1'b0;
            rd_window   <= 1'b0;
            wdata       <= '0;
        end else begin
            wdata_valid <= 1'b0;
            rd_window   <= 1'b0;
            wdata       <= '0;
            if (pop) begin
                eng_wait <= 1'b1;
                eng_rw   <= head.rw;
                eng_bl   <= head_bl;
                eng_data <= head.data;
                eng_dly  <= eff(head.rw ? cfg_wr_delay : cfg_rd_delay);
            end else if (eng_wait || (eng_run && eng_beat != eng_bl)) begin
                if (eng_wait && eng_dly != DLY_W'(1)) begin
                    eng_dly <= eng_dly - DLY_W'(1);
                end else begin
                    eng_wait    <= 1'b0;
                    eng_run     <= 1'b1;
                    eng_beat    <= eng_wait ? BEAT_W'(1) : eng_beat + BEAT_W'(1);
                    wdata_valid <= eng_rw;
                    rd_window   <= !eng_rw;
                    wdata       <= eng_rw ? eng_data[DATA_WIDTH-1:0] : '0;
                    eng_data    <= eng_data >> DATA_WIDTH;
                end
            end else begin
                eng_run <= 1'b0;
            end
        end
    end

    assign eng_busy_nxt = pop || eng_wait || (eng_run && eng_beat != eng_bl);

    always_ff @(posedge clock_t or negedge reset_n) begin
        if (!reset_n)
            busy <= 1'b0;
        else
            busy <= (count_nxt != '0) || (state_nxt != S_IDLE) || eng_busy_nxt;
    end
endmodule

// File: tb/tb_burst_data_pipe.sv
// Bench for burst_data_pipe: random requests checked against a transaction-level timing model.
module tb_burst_data_pipe;
    localparam int unsigned ADDR_WIDTH = 32;
    localparam int unsigned TA_WIDTH   = 29;
    localparam int unsigned ADDR_LSB   = 3;
    localparam int unsigned DATA_WIDTH = 64;
    localparam int unsigned BL_MAX     = 8;
    localparam int unsigned DEPTH      = 8;
    localparam int unsigned DLY_W      = 6;
    localparam int unsigned BURST_W    = BL_MAX * DATA_WIDTH;

    logic                  clock_t = 1'b0;
    logic                  reset_n = 1'b0;
    logic                  req_valid = 1'b0;
    logic                  req_ready;
    logic                  req_rw = 1'b0;
    logic [ADDR_WIDTH-1:0] req_addr = '0;
    logic [BURST_W-1:0]    req_wdata = '0;
    logic [DLY_W-1:0]      cfg_trcd = 6'd1, cfg_tccd = 6'd1, cfg_wr_delay = 6'd1, cfg_rd_delay = 6'd1;
    logic                  cfg_bl4 = 1'b0;
    logic                  cmd_valid;
    logic [1:0]            cmd_code;
    logic [TA_WIDTH-1:0]   cmd_addr;
    logic                  wdata_valid;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  rd_window;
    logic                  busy;

    always #5 clock_t = ~clock_t;

    burst_data_pipe dut (
        .clock_t(clock_t), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .cfg_trcd(cfg_trcd), .cfg_tccd(cfg_tccd),
        .cfg_wr_delay(cfg_wr_delay), .cfg_rd_delay(cfg_rd_delay), .cfg_bl4(cfg_bl4),
        .cmd_valid(cmd_valid), .cmd_code(cmd_code), .cmd_addr(cmd_addr),
        .wdata_valid(wdata_valid), .wdata(wdata), .rd_window(rd_window), .busy(busy)
    );

    typedef struct {
        logic                rw;
        logic                chop;
        logic [TA_WIDTH-1:0] addr;
        logic [BURST_W-1:0]  data;
        int                  bl;
        int                  trcd;
        int                  tccd;
        int                  dly;
    } exp_t;
    typedef struct {
        int                  cyc;
        logic [1:0]          code;
        logic [TA_WIDTH-1:0] addr;
    } cmd_t;
    typedef struct {
        int                    cyc;
        logic                  w;
        logic [DATA_WIDTH-1:0] data;
    } beat_t;

    exp_t  exp_q[$];
    cmd_t  cmd_q[$];
    beat_t beat_q[$];
    int    total = 0;
    int    bad = 0;
    int    cyc = 0;

    always @(posedge clock_t) cyc <= cyc + 1;

    // Event log of everything the DUT drives, time-stamped in cycles.
    always @(negedge clock_t) begin
        cmd_t  c;
        beat_t b;
        if (reset_n) begin
            if (cmd_valid) begin
                c.cyc = cyc; c.code = cmd_code; c.addr = cmd_addr;
                cmd_q.push_back(c);
            end
            if (wdata_valid) begin
                b.cyc = cyc; b.w = 1'b1; b.data = wdata;
                beat_q.push_back(b);
            end
            if (rd_window) begin
                b.cyc = cyc; b.w = 1'b0; b.data = '0;
                beat_q.push_back(b);
            end
        end
    end

    function automatic int eff(input int v);
        return (v == 0) ? 1 : v;
    endfunction

    function automatic logic [BURST_W-1:0] rand_burst();
        logic [BURST_W-1:0] d;
        d = '0;
        for (int i = 0; i < int'(BURST_W / 32); i++) d[i*32 +: 32] = $urandom();
        return d;
    endfunction

    task automatic model_push(input logic rw, input logic [ADDR_WIDTH-1:0] addr,
                              input logic [BURST_W-1:0] data, input logic bl4);
        exp_t e;
        e.rw   = rw;
        e.chop = bl4;
        e.addr = TA_WIDTH'(addr >> ADDR_LSB);
        e.data = data;
`ifdef BURST_CHOP_EN
        e.bl   = bl4 ? 4 : int'(BL_MAX);
`else
        e.bl   = int'(BL_MAX);
`endif
        e.trcd = eff(int'(cfg_trcd));
        e.tccd = eff(int'(cfg_tccd));
        e.dly  = rw ? eff(int'(cfg_wr_delay)) : eff(int'(cfg_rd_delay));
        exp_q.push_back(e);
    endtask

    task automatic send(input logic rw, input logic [ADDR_WIDTH-1:0] addr,
                        input logic [BURST_W-1:0] data, input logic bl4, output int waited);
        @(negedge clock_t);
        req_valid = 1'b1; req_rw = rw; req_addr = addr; req_wdata = data; cfg_bl4 = bl4;
        waited = 0;
        while (req_ready !== 1'b1 && waited < 500) begin
            @(negedge clock_t);
            waited++;
        end
        total++;
        if (req_ready !== 1'b1) begin
            bad++;
            $display("FAIL send_accept ready=%b after %0d cycles, want 1", req_ready, waited);
        end else begin
            model_push(rw, addr, data, bl4);
        end
        @(negedge clock_t);
        req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int quiet = 0;
        int n = 0;
        while (quiet < 4 && n < 3000) begin
            @(negedge clock_t);
            n++;
            if (!busy && !cmd_valid && !wdata_valid && !rd_window) quiet++;
            else quiet = 0;
        end
        total++;
        if (quiet < 4) begin
            bad++;
            $display("FAIL drain_timeout busy=%b after %0d cycles, want idle", busy, n);
        end
    endtask

    // Walk the expected transactions in order against the logged commands and beats.
    task automatic check_all(input string tag);
        exp_t               e;
        cmd_t               a, c;
        beat_t              b;
        logic [TA_WIDTH-1:0] exp_addr;
        logic [BURST_W-1:0] sh;
        int                 prev_last, prev_cas, prev_tccd, idx, last;
        prev_last = -1; prev_cas = 0; prev_tccd = 0; idx = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if (cmd_q.size() < 2) begin
                bad++;
                $display("FAIL %s cmd_missing txn%0d got %0d cmds want 2", tag, idx, cmd_q.size());
                exp_q.delete();
                break;
            end
            a = cmd_q.pop_front();
            c = cmd_q.pop_front();
            if (a.code !== 2'd1 || a.addr !== e.addr) begin
                bad++;
                $display("FAIL %s act txn%0d got code=%0d addr=%h want code=1 addr=%h", tag, idx, a.code, a.addr, e.addr);
            end
            if (prev_last >= 0) begin
                total++;
                if (a.cyc <= prev_last || a.cyc < prev_cas + prev_tccd) begin
                    bad++;
                    $display("FAIL %s act_spacing txn%0d got act@%0d want >%0d and >=%0d", tag, idx, a.cyc, prev_last, prev_cas + prev_tccd);
                end
            end
            exp_addr = e.addr;
`ifdef BURST_CHOP_EN
            exp_addr[12] = ~e.chop;
`endif
            total++;
            if (c.code !== (e.rw ? 2'd3 : 2'd2) || c.addr !== exp_addr) begin
                bad++;
                $display("FAIL %s cas txn%0d got code=%0d addr=%h want code=%0d addr=%h", tag, idx, c.code, c.addr, e.rw ? 3 : 2, exp_addr);
            end
            total++;
            if (c.cyc - a.cyc !== e.trcd) begin
                bad++;
                $display("FAIL %s trcd txn%0d got %0d want %0d", tag, idx, c.cyc - a.cyc, e.trcd);
            end
            sh = e.data;
            last = c.cyc;
            for (int k = 0; k < e.bl; k++) begin
                total++;
                if (beat_q.size() == 0) begin
                    bad++;
                    $display("FAIL %s beat_missing txn%0d beat%0d got none want %0d beats", tag, idx, k, e.bl);
                    break;
                end
                b = beat_q.pop_front();
                if (b.cyc !== c.cyc + e.dly + k || b.w !== e.rw || (e.rw && b.data !== sh[DATA_WIDTH-1:0])) begin
                    bad++;
                    $display("FAIL %s beat txn%0d beat%0d got cyc=%0d w=%b data=%h want cyc=%0d w=%b data=%h",
                             tag, idx, k, b.cyc, b.w, b.data, c.cyc + e.dly + k, e.rw, sh[DATA_WIDTH-1:0]);
                end
                last = b.cyc;
                sh = sh >> DATA_WIDTH;
            end
            prev_last = last; prev_cas = c.cyc; prev_tccd = e.tccd;
            idx++;
        end
        total++;
        if (cmd_q.size() != 0 || beat_q.size() != 0) begin
            bad++;
            $display("FAIL %s leftover got cmds=%0d beats=%0d want 0 0", tag, cmd_q.size(), beat_q.size());
        end
        cmd_q.delete();
        beat_q.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        total++;
        if (req_ready !== 1'b1 || cmd_valid !== 1'b0 || cmd_code !== 2'd0 || cmd_addr !== '0 ||
            wdata_valid !== 1'b0 || wdata !== '0 || rd_window !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL %s reset_outputs got rdy=%b cv=%b cc=%0d ca=%h wv=%b wd=%h rw=%b busy=%b want 1 0 0 0 0 0 0 0",
                     tag, req_ready, cmd_valid, cmd_code, cmd_addr, wdata_valid, wdata, rd_window, busy);
        end
    endtask

    task automatic test_reset();
        logic [BURST_W-1:0] d;
        d = rand_burst();
        cfg_trcd = 6'd3; cfg_tccd = 6'd1; cfg_wr_delay = 6'd5; cfg_rd_delay = 6'd2;
        reset_n = 1'b0;
        req_valid = 1'b1; req_rw = 1'b1; req_addr = 32'h0000_0108; req_wdata = d; cfg_bl4 = 1'b0;
        repeat (4) @(negedge clock_t);
        check_reset_outputs("reset_held");
        reset_n = 1'b1;
        model_push(1'b1, 32'h0000_0108, d, 1'b0);
        @(negedge clock_t);
        req_valid = 1'b0;
        wait_idle();
        total++;
        if (cmd_q.size() == 0 || cmd_q[0].addr !== 29'h21) begin
            bad++;
            $display("FAIL first_map got %h want 00000021", cmd_q.size() ? cmd_q[0].addr : '1);
        end
        total++;
        if (cmd_q.size() == 0 || beat_q.size() == 0 || beat_q[0].cyc - cmd_q[0].cyc !== 8) begin
            bad++;
            $display("FAIL first_beat_offset got %0d want 8", (cmd_q.size() && beat_q.size()) ? beat_q[0].cyc - cmd_q[0].cyc : -1);
        end
        check_all("first_write");
    endtask

    task automatic test_fill();
        int w;
        cfg_trcd = 6'd63; cfg_tccd = 6'd1; cfg_wr_delay = 6'd1;
        for (int i = 0; i < int'(DEPTH); i++) begin
            send(1'b1, $urandom(), rand_burst(), 1'b0, w);
            total++;
            if (req_ready !== (i < int'(DEPTH) - 1)) begin
                bad++;
                $display("FAIL fill_ready after accept %0d got %b want %b", i + 1, req_ready, i < int'(DEPTH) - 1);
            end
        end
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL fill_busy got %b want 1", busy);
        end
        send(1'b0, $urandom(), rand_burst(), 1'b0, w);
        total++;
        if (w == 0) begin
            bad++;
            $display("FAIL fill_hold got wait=%0d want >0", w);
        end
        wait_idle();
        check_all("fill");
    endtask

    task automatic test_read();
        int w;
        cfg_trcd = 6'd2; cfg_tccd = 6'd1; cfg_rd_delay = 6'd2;
        send(1'b0, $urandom(), rand_burst(), 1'b0, w);
        wait_idle();
        check_all("read");
    endtask

    task automatic test_back_to_back();
        int w;
        cfg_trcd = 6'd1; cfg_tccd = 6'd1; cfg_wr_delay = 6'd1; cfg_rd_delay = 6'd1;
        send(1'b1, $urandom(), rand_burst(), 1'b0, w);
        send(1'b1, $urandom(), rand_burst(), 1'b0, w);
        send(1'b0, $urandom(), rand_burst(), 1'b0, w);
        wait_idle();
        check_all("back_to_back");
    endtask

    task automatic test_zero_timing();
        int w;
        cfg_trcd = 6'd0; cfg_tccd = 6'd0; cfg_wr_delay = 6'd0; cfg_rd_delay = 6'd0;
        for (int i = 0; i < 3; i++) send(1'($urandom_range(0, 1)), $urandom(), rand_burst(), 1'b0, w);
        wait_idle();
        check_all("zero_timing");
    endtask

    task automatic test_chop();
        int w;
        cfg_trcd = 6'd2; cfg_tccd = 6'd2; cfg_wr_delay = 6'd3; cfg_rd_delay = 6'd2;
        send(1'b1, 32'h0000_0000, rand_burst(), 1'b1, w);
        send(1'b1, 32'hFFFF_FFF8, rand_burst(), 1'b0, w);
        send(1'b0, 32'h0000_8000, rand_burst(), 1'b1, w);
        wait_idle();
        check_all("chop");
    endtask

    task automatic test_random();
        int w;
        for (int r = 0; r < 4; r++) begin
            cfg_trcd = DLY_W'($urandom_range(0, 5));
            cfg_tccd = DLY_W'($urandom_range(0, 4));
            cfg_wr_delay = DLY_W'($urandom_range(0, 7));
            cfg_rd_delay = DLY_W'($urandom_range(0, 7));
            for (int i = 0; i < 5; i++) begin
                send(1'($urandom_range(0, 1)), $urandom(), rand_burst(), 1'($urandom_range(0, 1)), w);
                repeat ($urandom_range(0, 3)) @(negedge clock_t);
            end
            wait_idle();
            check_all("random");
        end
    endtask

    task automatic test_mid_reset();
        int w;
        int n = 0;
        cfg_trcd = 6'd1; cfg_tccd = 6'd1; cfg_wr_delay = 6'd4;
        send(1'b1, $urandom(), rand_burst(), 1'b0, w);
        send(1'b1, $urandom(), rand_burst(), 1'b0, w);
        while (wdata_valid !== 1'b1 && n < 200) begin
            @(negedge clock_t);
            n++;
        end
        total++;
        if (wdata_valid !== 1'b1) begin
            bad++;
            $display("FAIL mid_reset_start got wdata_valid=%b want 1", wdata_valid);
        end
        reset_n = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        exp_q.delete();
        @(negedge clock_t);
        cmd_q.delete();
        beat_q.delete();
        reset_n = 1'b1;
        repeat (30) @(negedge clock_t);
        total++;
        if (cmd_q.size() != 0 || beat_q.size() != 0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset_discard got cmds=%0d beats=%0d busy=%b want 0 0 0", cmd_q.size(), beat_q.size(), busy);
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_fill();
        test_read();
        test_back_to_back();
        test_zero_timing();
        test_chop();
        test_random();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
